// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg -- shared FSM state type and sizing constants for the boot loader.
// Revision: 1.0
`default_nettype none

package boot_loader_pkg;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_TIMEOUT = 1000;
    localparam int COUNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// word_packer -- assembles big-endian 32-bit words from a byte stream.
// Revision: 1.0
`default_nettype none

module word_packer
    import boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Strobe fires with the 4th byte; the word includes that byte directly.
    assign word_done_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o      = {shift_q, byte_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// boot_loader -- loads a length/payload/checksum byte stream into instruction memory.
// Revision: 1.0
`default_nettype none

module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        cpu_reset_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [7:0]           len_hi_q, len_hi_d;
    logic [COUNT_W-1:0]   n_q, n_d;
    logic [COUNT_W-1:0]   word_idx_q, word_idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 wr_en_q, wr_en_d;
    logic [31:0]          wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 cpu_run_q;

    logic                 busy;
    logic                 fire;
    logic                 timeout_hit;
    logic                 pack_clear;
    logic                 pack_valid;
    logic                 word_done;
    logic [31:0]          word;
    logic [COUNT_W-1:0]   len_full;

    assign busy = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                  (state_q == ST_DATA)   || (state_q == ST_CSUM);

    // Holding off the checksum byte while the last word is written keeps the
    // write and the checksum comparison in separate cycles.
    assign rx_ready_o = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA)   || ((state_q == ST_CSUM) && !wr_en_q);

    assign fire       = rx_valid_i && rx_ready_o;
    assign pack_valid = fire && (state_q == ST_DATA);
    assign len_full   = {len_hi_q, rx_data_i};

    word_packer u_word_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data_i),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        idle_d      = idle_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pack_clear  = 1'b0;
        timeout_hit = 1'b0;

        if (busy) begin
            if (fire) begin
                idle_d = '0;
            end else begin
                idle_d      = idle_q + IDLE_W'(1);
                timeout_hit = (idle_q == IDLE_W'(TIMEOUT - 1));
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LEN_HI;
                    len_hi_d   = '0;
                    n_d        = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    idle_d     = '0;
                    pack_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (fire) begin
                    len_hi_d = rx_data_i;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (fire) begin
                    n_d = len_full;
                    if (32'(len_full) > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (len_full == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ rx_data_i;
                    if (word_done) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = 32'({word_idx_q, 2'b00});
                        wr_data_d  = word;
                        word_idx_d = word_idx_q + COUNT_W'(1);
                        if (word_idx_q == n_q - COUNT_W'(1)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (fire) begin
                    state_d = (rx_data_i == csum_q) ? ST_RUN : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_hit) begin
            state_d = ST_ERR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            idle_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            idle_q     <= idle_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_run_q  <= (state_d == ST_RUN);
        end
    end

    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign cpu_reset_n_o = cpu_run_q;
    assign busy_o        = busy;
    assign done_o        = (state_q == ST_RUN);
    assign error_o       = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// tb_boot_loader -- directed self-checking bench for boot_loader.
// Revision: 1.0
`default_nettype none

module tb_boot_loader;

    localparam int TB_DEPTH   = 256;
    localparam int TB_TIMEOUT = 20;

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b0;
    logic        start_i    = 1'b0;
    logic [7:0]  rx_data_i  = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        cpu_reset_n_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int checks   = 0;
    int failures = 0;

    int          wr_n = 0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];

    boot_loader #(
        .DEPTH   (TB_DEPTH),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .cpu_reset_n_o (cpu_reset_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    // One log entry per cycle with wr_en high, so a stretched pulse shows up as extra writes.
    always @(negedge clk_i) begin
        if (wr_en_o === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr_log[wr_n] = wr_addr_o;
                wr_data_log[wr_n] = wr_data_o;
            end
            wr_n++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (rx_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            failures++;
            $display("FAIL send_byte: rx_ready=%b required 1 for byte %h", rx_ready_o, b);
        end
        @(negedge clk_i);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid_i = 1'b0;
        rst_ni     = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic send_two_words(input logic [7:0] cs);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(cs);
        rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        #1;
        checks++;
        if ({rx_ready_o, wr_en_o, cpu_reset_n_o, busy_o, done_o, error_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got rdy/wr/cpu/busy/done/err=%b required 000000",
                     {rx_ready_o, wr_en_o, cpu_reset_n_o, busy_o, done_o, error_o});
        end
        checks++;
        if (wr_addr_o !== 32'h0 || wr_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h data=%h required 0/0", wr_addr_o, wr_data_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || rx_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b rx_ready=%b required 0/0", busy_o, rx_ready_o);
        end
    endtask

    task automatic test_good_load();
        int base = wr_n;
        pulse_start();
        checks++;
        if (busy_o !== 1'b1 || rx_ready_o !== 1'b1 || cpu_reset_n_o !== 1'b0) begin
            failures++;
            $display("FAIL good_start: busy=%b rdy=%b cpu=%b required 1/1/0", busy_o, rx_ready_o, cpu_reset_n_o);
        end
        send_two_words(8'h2D);
        checks++;
        if (done_o !== 1'b1 || cpu_reset_n_o !== 1'b1 || busy_o !== 1'b0 || error_o !== 1'b0) begin
            failures++;
            $display("FAIL good_done: done=%b cpu=%b busy=%b err=%b required 1/1/0/0",
                     done_o, cpu_reset_n_o, busy_o, error_o);
        end
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (wr_n - base !== 2) begin
            failures++;
            $display("FAIL good_wr_count: got %0d writes required 2", wr_n - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h20080005) begin
                failures++;
                $display("FAIL good_wr0: addr=%h data=%h required 00000000/20080005",
                         wr_addr_log[base], wr_data_log[base]);
            end
            checks++;
            if (wr_addr_log[base+1] !== 32'h4 || wr_data_log[base+1] !== 32'h0) begin
                failures++;
                $display("FAIL good_wr1: addr=%h data=%h required 00000004/00000000",
                         wr_addr_log[base+1], wr_data_log[base+1]);
            end
        end
        checks++;
        if (wr_addr_o !== 32'h4 || wr_en_o !== 1'b0) begin
            failures++;
            $display("FAIL good_hold: addr=%h wr_en=%b required 00000004/0", wr_addr_o, wr_en_o);
        end
    endtask

    task automatic test_bad_csum();
        int base = wr_n;
        pulse_start();
        checks++;
        if (cpu_reset_n_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL restart_from_run: cpu=%b busy=%b done=%b required 0/1/0",
                     cpu_reset_n_o, busy_o, done_o);
        end
        send_two_words(8'h00);
        checks++;
        if (error_o !== 1'b1 || cpu_reset_n_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_csum: err=%b cpu=%b done=%b required 1/0/0", error_o, cpu_reset_n_o, done_o);
        end
        #1;
        checks++;
        if (wr_n - base !== 2) begin
            failures++;
            $display("FAIL bad_csum_writes: got %0d writes required 2", wr_n - base);
        end
    endtask

    task automatic test_oversize();
        int base = wr_n;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid_i = 1'b0;
        checks++;
        if (error_o !== 1'b1 || busy_o !== 1'b0 || rx_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL oversize_err: err=%b busy=%b rdy=%b required 1/0/0", error_o, busy_o, rx_ready_o);
        end
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (wr_n !== base) begin
            failures++;
            $display("FAIL oversize_writes: got %0d writes required 0", wr_n - base);
        end
        // N equal to DEPTH is still legal.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        rx_valid_i = 1'b0;
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL depth_limit: err=%b busy=%b required 0/1", error_o, busy_o);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int base = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        rx_valid_i = 1'b0;
        repeat (TB_TIMEOUT - 1) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || error_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: busy=%b err=%b required 1/0", busy_o, error_o);
        end
        @(negedge clk_i);
        checks++;
        if (error_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err: err=%b busy=%b required 1/0", error_o, busy_o);
        end
        #1;
        checks++;
        if (wr_n !== base) begin
            failures++;
            $display("FAIL timeout_writes: got %0d writes required 0", wr_n - base);
        end
    endtask

    task automatic test_zero_len();
        int base = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        rx_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || cpu_reset_n_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_done: done=%b cpu=%b required 1/1", done_o, cpu_reset_n_o);
        end
        #1;
        checks++;
        if (wr_n !== base) begin
            failures++;
            $display("FAIL zero_len_writes: got %0d writes required 0", wr_n - base);
        end
        pulse_start();
        checks++;
        if (cpu_reset_n_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_restart: cpu=%b busy=%b done=%b required 0/1/0",
                     cpu_reset_n_o, busy_o, done_o);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int base = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rx_data_i = 8'h00;
        rst_ni    = 1'b0;
        #1;
        checks++;
        if ({rx_ready_o, wr_en_o, cpu_reset_n_o, busy_o, done_o, error_o} !== 6'b0 ||
            wr_addr_o !== 32'h0 || wr_data_o !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: flags=%b addr=%h data=%h required 000000/0/0",
                     {rx_ready_o, wr_en_o, cpu_reset_n_o, busy_o, done_o, error_o}, wr_addr_o, wr_data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_n - base !== 1) begin
            failures++;
            $display("FAIL mid_reset_after: busy=%b done=%b writes=%0d required 0/0/1",
                     busy_o, done_o, wr_n - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h11223344) begin
                failures++;
                $display("FAIL mid_reset_word0: addr=%h data=%h required 00000000/11223344",
                         wr_addr_log[base], wr_data_log[base]);
            end
        end
        // rx_valid still high with 0x00: a new start consumes len 0, checksum 0.
        @(negedge clk_i);
        pulse_start();
        repeat (4) @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || wr_n - base !== 1) begin
            failures++;
            $display("FAIL held_valid_restart: done=%b writes=%0d required 1/1", done_o, wr_n - base);
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h22);
        rx_valid_i = 1'b0;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h08);
        rx_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || cpu_reset_n_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: done=%b cpu=%b required 1/1", done_o, cpu_reset_n_o);
        end
        #1;
        checks++;
        if (wr_n - base !== 2) begin
            failures++;
            $display("FAIL b2b_writes: got %0d writes required 2", wr_n - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'hDEADBEEF ||
                wr_addr_log[base+1] !== 32'h0 || wr_data_log[base+1] !== 32'h12345678) begin
                failures++;
                $display("FAIL b2b_data: %h@%h %h@%h required DEADBEEF@0 12345678@0",
                         wr_data_log[base], wr_addr_log[base], wr_data_log[base+1], wr_addr_log[base+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_oversize();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
